video_beam_timing: RTL and testbench
====================================

Name: video_beam_timing

Overview:
- Parametrised successor to the fixed PAL/NTSC beam counter; generates horizontal/vertical beam positions, sync, blanking and interlace frame parity from a programmable register set.
- Sits between the chipset register bus and the scandoubler. Feeds hpos/vpos, _hsync/_vsync, blank, long_frame and htotal_out downstream.
- Generalised over counter widths and register defaults. Adds interlace half-line vsync offset and double-buffered total registers.

Parameters:
- HW, 9, horizontal counter width (bits)
- VW, 11, vertical counter width (bits)
- HTOTAL_DEF, 227, reset value of htotal (last hpos of a line)
- VTOTAL_DEF, 312, reset value of vtotal (last vpos of a short frame)
- HSSTRT_DEF / HSSTOP_DEF, 18 / 35, reset hsync window
- VSSTRT_DEF / VSSTOP_DEF, 2 / 5, reset vsync lines
- HBSTRT_DEF / HBSTOP_DEF, 9 / 44, reset hblank window
- VBSTRT_DEF / VBSTOP_DEF, 0 / 25, reset vblank lines

Ports:
- clk  in  1  system clock (28 MHz)
- reset  in  1  asynchronous reset, active-high
- pix_en  in  1  counter advance enable (one per CCK)
- wr  in  1  register write strobe
- reg_address  in  4  register select: 0 htotal, 1 hsstrt, 2 hsstop, 3 hbstrt, 4 hbstop, 5 vtotal, 6 vsstrt, 7 vsstop, 8 vbstrt, 9 vbstop, 10 ctrl; 11-15 ignored
- data_in  in  16  write data, low HW/VW bits used; ctrl[0]=lace, ctrl[1]=hsyncpol, ctrl[2]=vsyncpol
- hpos  out  HW  horizontal beam position
- vpos  out  VW  vertical beam position
- _hsync  out  1  horizontal sync; active-low when hsyncpol=0
- _vsync  out  1  vertical sync; active-low when vsyncpol=0
- blank  out  1  hblank OR vblank
- eol  out  1  one-cycle pulse on the pix_en where hpos wraps
- eof  out  1  one-cycle pulse on the pix_en where vpos wraps
- long_frame  out  1  current frame is long (odd field)
- htotal_out  out  HW  active htotal

Behaviour:
- Reset values:
  - hpos=0, vpos=0, eol=0, eof=0, long_frame=1, blank=1, _hsync=1, _vsync=1, ctrl=0.
  - All registers load their *_DEF values; htotal_out=HTOTAL_DEF.
- Reset asserted mid-line clears everything immediately (asynchronous).
- Horizontal counter: on pix_en, if hpos>=htotal_act then hpos<=0 and eol pulses; otherwise hpos+1.
  - The >= compare means a htotal reduced below the current hpos wraps on the next pix_en.
- Vertical counter: advances on eol. Wrap point is vtotal_act+1 when long_frame=1 and lace=1, else vtotal_act.
  - On wrap: vpos<=0, eof pulses, and long_frame<=~long_frame if lace=1, else long_frame<=1.
- Double buffering:
  - htotal and vtotal writes go to shadow registers.
  - Shadows copy into htotal_act/vtotal_act on the pix_en carrying eof, so totals never change mid-frame.
  - All other registers take effect on the cycle after the write.
- Write with wr and pix_en in the same cycle: the counter uses old values and the register updates.
- Sync generation:
  - hsync active for hsstrt<=hpos<hsstop.
  - In a long frame, or with lace=0, vsync asserts at hpos==hsstrt of line vsstrt and deasserts at hpos==hsstrt of line vsstop.
  - In a short frame with lace=1, both edges move to hpos==htotal_act>>1 (half-line offset).
- Blanking: hblank for hbstrt<=hpos<hbstop; vblank for vbstrt<=vpos<vbstop. Equal start/stop means the window is never active.
- Output latency: hpos, vpos, eol, eof and long_frame change on the same edge as the counter. Sync and blank are registered and lag the counters by exactly one clk.
- Polarity: the xsyncpol bit inverts the corresponding active level.

Optional Feature:
- Macro VIDEO_BEAM_CSYNC_EN.
- Defined: adds output _csync (1 bit), an XNOR of the active-low hsync and vsync (serration during vsync), registered with the same one-clk latency. Active-low regardless of the pol bits; reset value 1.
- Undefined: the port is absent and no csync logic is built.

Test Plan:
- Reset release, pix_en every 4 clk, defaults -> eol every 228 pix_en; eof after 313 lines; long_frame stays 1; _hsync low for hpos 18..34.
- Write ctrl=1 (lace) -> frame lengths alternate 314/313 lines. long_frame toggles on each eof. On short frames _vsync falls at hpos=113 of line 2.
- Write htotal=99 at vpos=100 -> line length stays 228 until eof, then 100; htotal_out changes on the eof cycle.
- Write hbstrt=hbstop=40 and vbstrt=vbstop=0 -> blank never asserts over a full frame.
- Set ctrl[1]=1 -> _hsync high for hpos 18..34, low elsewhere, one clk after the hpos change.
- Assert reset at hpos=150, vpos=200 -> all outputs return to their reset values immediately; counting restarts from 0,0 after release.

Source files
------------

// File: rtl/video_beam_timing.sv
// Programmable beam counter: hpos/vpos, sync, blanking and interlace parity from a register set.
// Latency: counters update on the pix_en edge; sync/blank are registered one clk behind the counters.
// Backpressure: none; pix_en paces the counters and register writes are always accepted.
// Optional VIDEO_BEAM_CSYNC_EN adds the _csync output (serrated composite sync).
module video_beam_timing #(
    parameter int HW         = 9,
    parameter int VW         = 11,
    parameter int HTOTAL_DEF = 227,
    parameter int VTOTAL_DEF = 312,
    parameter int HSSTRT_DEF = 18,
    parameter int HSSTOP_DEF = 35,
    parameter int VSSTRT_DEF = 2,
    parameter int VSSTOP_DEF = 5,
    parameter int HBSTRT_DEF = 9,
    parameter int HBSTOP_DEF = 44,
    parameter int VBSTRT_DEF = 0,
    parameter int VBSTOP_DEF = 25
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          wr,
    input  logic [3:0]    reg_address,
    input  logic [15:0]   data_in,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          _hsync,
    output logic          _vsync,
    output logic          blank,
    output logic          eol,
    output logic          eof,
    output logic          long_frame,
    output logic [HW-1:0] htotal_out
`ifdef VIDEO_BEAM_CSYNC_EN
    ,
    output logic          _csync
`endif
);

    // register file: shadow totals, sync/blank windows, control bits
    logic [HW-1:0] htotal_sh_q, htotal_sh_d;
    logic [VW-1:0] vtotal_sh_q, vtotal_sh_d;
    logic [HW-1:0] hsstrt_q, hsstrt_d, hsstop_q, hsstop_d;
    logic [HW-1:0] hbstrt_q, hbstrt_d, hbstop_q, hbstop_d;
    logic [VW-1:0] vsstrt_q, vsstrt_d, vsstop_q, vsstop_d;
    logic [VW-1:0] vbstrt_q, vbstrt_d, vbstop_q, vbstop_d;
    logic [2:0]    ctrl_q, ctrl_d;

    // counter state and the totals actually in use this frame
    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic          eol_q, eol_d, eof_q, eof_d;
    logic          long_frame_q, long_frame_d;
    logic [HW-1:0] htotal_act_q, htotal_act_d;
    logic [VW-1:0] vtotal_act_q, vtotal_act_d;

    // registered sync/blank outputs
    logic          vs_on_q, vs_on_d;
    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic          blank_q, blank_d;

    logic          lace;
    logic          hwrap, vwrap;
    logic [VW-1:0] vlast;
    logic          hs_win, hb_win, vb_win;
    logic [HW-1:0] vs_edge_h;
    logic          vs_set, vs_clr;

    // only the low HW/VW bits of write data are meaningful
    logic unused_data;
    assign unused_data = ^data_in;

    assign lace = ctrl_q[0];

    // decode register writes; new values are visible the cycle after the write
    always_comb begin
        htotal_sh_d = htotal_sh_q;
        vtotal_sh_d = vtotal_sh_q;
        hsstrt_d    = hsstrt_q;
        hsstop_d    = hsstop_q;
        hbstrt_d    = hbstrt_q;
        hbstop_d    = hbstop_q;
        vsstrt_d    = vsstrt_q;
        vsstop_d    = vsstop_q;
        vbstrt_d    = vbstrt_q;
        vbstop_d    = vbstop_q;
        ctrl_d      = ctrl_q;
        if (wr) begin
            case (reg_address)
                4'd0:    htotal_sh_d = data_in[HW-1:0];
                4'd1:    hsstrt_d    = data_in[HW-1:0];
                4'd2:    hsstop_d    = data_in[HW-1:0];
                4'd3:    hbstrt_d    = data_in[HW-1:0];
                4'd4:    hbstop_d    = data_in[HW-1:0];
                4'd5:    vtotal_sh_d = data_in[VW-1:0];
                4'd6:    vsstrt_d    = data_in[VW-1:0];
                4'd7:    vsstop_d    = data_in[VW-1:0];
                4'd8:    vbstrt_d    = data_in[VW-1:0];
                4'd9:    vbstop_d    = data_in[VW-1:0];
                4'd10:   ctrl_d      = data_in[2:0];
                default: ;
            endcase
        end
    end

    // next beam position; totals swap in only on the pix_en that wraps the frame
    always_comb begin
        hwrap        = (hpos_q >= htotal_act_q);
        vlast        = vtotal_act_q + VW'(lace & long_frame_q);
        vwrap        = (vpos_q >= vlast);
        hpos_d       = hpos_q;
        vpos_d       = vpos_q;
        eol_d        = 1'b0;
        eof_d        = 1'b0;
        long_frame_d = long_frame_q;
        htotal_act_d = htotal_act_q;
        vtotal_act_d = vtotal_act_q;
        if (pix_en) begin
            if (hwrap) begin
                hpos_d = '0;
                eol_d  = 1'b1;
                if (vwrap) begin
                    vpos_d       = '0;
                    eof_d        = 1'b1;
                    long_frame_d = lace ? ~long_frame_q : 1'b1;
                    htotal_act_d = htotal_sh_q;
                    vtotal_act_d = vtotal_sh_q;
                end else begin
                    vpos_d = vpos_q + 1'b1;
                end
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
        end
    end

    // sync and blank decode from the current counters; short interlaced frames move vsync edges to mid-line
    always_comb begin
        hs_win    = (hpos_q >= hsstrt_q) && (hpos_q < hsstop_q);
        hb_win    = (hpos_q >= hbstrt_q) && (hpos_q < hbstop_q);
        vb_win    = (vpos_q >= vbstrt_q) && (vpos_q < vbstop_q);
        vs_edge_h = (lace && !long_frame_q) ? (htotal_act_q >> 1) : hsstrt_q;
        vs_set    = (hpos_q == vs_edge_h) && (vpos_q == vsstrt_q);
        vs_clr    = (hpos_q == vs_edge_h) && (vpos_q == vsstop_q);
        vs_on_d   = (vs_on_q | vs_set) & ~vs_clr;
        hsync_n_d = hs_win ~^ ctrl_q[1];
        vsync_n_d = vs_on_d ~^ ctrl_q[2];
        blank_d   = hb_win | vb_win;
    end

    // all state, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            htotal_sh_q  <= HW'(HTOTAL_DEF);
            vtotal_sh_q  <= VW'(VTOTAL_DEF);
            hsstrt_q     <= HW'(HSSTRT_DEF);
            hsstop_q     <= HW'(HSSTOP_DEF);
            hbstrt_q     <= HW'(HBSTRT_DEF);
            hbstop_q     <= HW'(HBSTOP_DEF);
            vsstrt_q     <= VW'(VSSTRT_DEF);
            vsstop_q     <= VW'(VSSTOP_DEF);
            vbstrt_q     <= VW'(VBSTRT_DEF);
            vbstop_q     <= VW'(VBSTOP_DEF);
            ctrl_q       <= '0;
            hpos_q       <= '0;
            vpos_q       <= '0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            long_frame_q <= 1'b1;
            htotal_act_q <= HW'(HTOTAL_DEF);
            vtotal_act_q <= VW'(VTOTAL_DEF);
            vs_on_q      <= 1'b0;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
            blank_q      <= 1'b1;
        end else begin
            htotal_sh_q  <= htotal_sh_d;
            vtotal_sh_q  <= vtotal_sh_d;
            hsstrt_q     <= hsstrt_d;
            hsstop_q     <= hsstop_d;
            hbstrt_q     <= hbstrt_d;
            hbstop_q     <= hbstop_d;
            vsstrt_q     <= vsstrt_d;
            vsstop_q     <= vsstop_d;
            vbstrt_q     <= vbstrt_d;
            vbstop_q     <= vbstop_d;
            ctrl_q       <= ctrl_d;
            hpos_q       <= hpos_d;
            vpos_q       <= vpos_d;
            eol_q        <= eol_d;
            eof_q        <= eof_d;
            long_frame_q <= long_frame_d;
            htotal_act_q <= htotal_act_d;
            vtotal_act_q <= vtotal_act_d;
            vs_on_q      <= vs_on_d;
            hsync_n_q    <= hsync_n_d;
            vsync_n_q    <= vsync_n_d;
            blank_q      <= blank_d;
        end
    end

`ifdef VIDEO_BEAM_CSYNC_EN
    logic csync_n_q, csync_n_d;

    // composite sync: XNOR of the active-low syncs, inverting hsync inside vsync
    always_comb begin
        csync_n_d = (~hs_win) ~^ (~vs_on_d);
    end

    // composite sync register, same one-clk lag as the other syncs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csync_n_q <= 1'b1;
        end else begin
            csync_n_q <= csync_n_d;
        end
    end

    assign _csync = csync_n_q;
`endif

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign eol        = eol_q;
    assign eof        = eof_q;
    assign long_frame = long_frame_q;
    assign htotal_out = htotal_act_q;
    assign _hsync     = hsync_n_q;
    assign _vsync     = vsync_n_q;
    assign blank      = blank_q;

endmodule

// File: tb/tb_video_beam_timing.sv
// Directed bench for video_beam_timing: line/frame lengths, interlace, double-buffered totals,
// blanking, sync polarity/lag and asynchronous reset. Vertical defaults are shrunk (vtotal 24,
// vblank stop 8) so several whole frames fit in a short run; horizontal defaults are untouched.
module tb_video_beam_timing;

    logic        clk;
    logic        reset;
    logic        pix_en;
    logic        wr;
    logic [3:0]  reg_address;
    logic [15:0] data_in;
    logic [8:0]  hpos;
    logic [10:0] vpos;
    logic        _hsync, _vsync, blank, eol, eof, long_frame;
    logic [8:0]  htotal_out;
`ifdef VIDEO_BEAM_CSYNC_EN
    logic        _csync;
`endif

    video_beam_timing #(
        .VTOTAL_DEF (24),
        .VBSTOP_DEF (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .wr          (wr),
        .reg_address (reg_address),
        .data_in     (data_in),
        .hpos        (hpos),
        .vpos        (vpos),
        ._hsync      (_hsync),
        ._vsync      (_vsync),
        .blank       (blank),
        .eol         (eol),
        .eof         (eof),
        .long_frame  (long_frame),
        .htotal_out  (htotal_out)
`ifdef VIDEO_BEAM_CSYNC_EN
        ,
        ._csync      (_csync)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model copies of the programmed windows
    int   m_hsstrt = 18, m_hsstop = 35;
    int   m_hbstrt = 9,  m_hbstop = 44;
    int   m_vbstrt = 0,  m_vbstop = 8;
    logic m_hpol   = 1'b0;

    int   prev_h, prev_v, prev_htot;
    logic prev_vs;
    int   hs_err, bl_err, bl_cnt;

    int pe_period = 4;
    int pe_cnt    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pix_en strobe, one clk in every pe_period, driven away from the active edge
    initial begin
        pix_en = 1'b0;
        forever begin
            @(negedge clk);
            pe_cnt++;
            pix_en = ((pe_cnt % pe_period) == 0);
        end
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one clk and sample 1 ns after the edge; sync/blank are compared
    // against the counters as they were before the edge
    task automatic step();
        logic win, hs_e, bl_e;
        prev_h    = int'(hpos);
        prev_v    = int'(vpos);
        prev_htot = int'(htotal_out);
        prev_vs   = _vsync;
        @(posedge clk);
        #1;
        win  = (prev_h >= m_hsstrt) && (prev_h < m_hsstop);
        hs_e = m_hpol ? win : !win;
        bl_e = ((prev_h >= m_hbstrt) && (prev_h < m_hbstop)) ||
               ((prev_v >= m_vbstrt) && (prev_v < m_vbstop));
        if (_hsync !== hs_e) hs_err++;
        if (blank !== bl_e) bl_err++;
        if (blank === 1'b1) bl_cnt++;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        wr          = 1'b1;
        reg_address = a;
        data_in     = d;
        step();
        wr          = 1'b0;
    endtask

    task automatic clr_err();
        hs_err = 0;
        bl_err = 0;
        bl_cnt = 0;
    endtask

    // clocks until the next eol pulse
    task automatic wait_eol(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (eol !== 1'b1 && n < 20000);
        if (eol !== 1'b1) chk("eol_timeout", 0, 1);
    endtask

    // run to the next eof, recording line count and vsync edge positions
    task automatic run_frame(output int lines, output int fh, output int fv,
                             output int rh, output int rv);
        int n;
        n = 0; lines = 0; fh = -1; fv = -1; rh = -1; rv = -1;
        do begin
            step();
            n++;
            if (eol === 1'b1) lines++;
            if (prev_vs === 1'b1 && _vsync === 1'b0) begin fh = prev_h; fv = prev_v; end
            if (prev_vs === 1'b0 && _vsync === 1'b1) begin rh = prev_h; rv = prev_v; end
        end while (eof !== 1'b1 && n < 40000);
        if (eof !== 1'b1) chk("eof_timeout", 0, 1);
    endtask

    initial begin
        int n, lines, fh, fv, rh, rv;
        wr = 1'b0; reg_address = '0; data_in = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        clr_err();
        #20;
        chk("rst_hpos", hpos, 0);
        chk("rst_vpos", vpos, 0);
        chk("rst_eol", eol, 0);
        chk("rst_eof", eof, 0);
        chk("rst_long", long_frame, 1);
        chk("rst_blank", blank, 1);
        chk("rst_hsync", _hsync, 1);
        chk("rst_vsync", _vsync, 1);
        chk("rst_htotal", htotal_out, 227);
        @(negedge clk);
        reset = 1'b0;

        // default line: 228 pix_en at one pix_en per 4 clk
        wait_eol(n);
        clr_err();
        wait_eol(n);
        chk("line_len_def", n, 912);
        chk("hsync_line_p4", hs_err, 0);
        chk("blank_line_p4", bl_err, 0);
        step();
        chk("eol_one_clk", eol, 0);

        // full non-interlaced frame at pix_en every clk
        pe_period = 1;
        run_frame(lines, fh, fv, rh, rv);
        clr_err();
        run_frame(lines, fh, fv, rh, rv);
        chk("frame_lines", lines, 25);
        chk("frame_long", long_frame, 1);
        chk("vs_fall_h", fh, 18);
        chk("vs_fall_v", fv, 2);
        chk("vs_rise_h", rh, 18);
        chk("vs_rise_v", rv, 5);
        chk("hsync_frame", hs_err, 0);
        chk("blank_frame", bl_err, 0);

        // interlace: long (26) / short (25) alternation with half-line vsync on short frames
        wr_reg(4'd10, 16'h0001);
        run_frame(lines, fh, fv, rh, rv);
        chk("lace_long_lines", lines, 26);
        chk("lace_long_fall_h", fh, 18);
        chk("lace_long_after", long_frame, 0);
        run_frame(lines, fh, fv, rh, rv);
        chk("lace_short_lines", lines, 25);
        chk("lace_short_fall_h", fh, 113);
        chk("lace_short_fall_v", fv, 2);
        chk("lace_short_rise_h", rh, 113);
        chk("lace_short_after", long_frame, 1);
        run_frame(lines, fh, fv, rh, rv);
        chk("lace_long2_lines", lines, 26);
        chk("lace_long2_after", long_frame, 0);
        wr_reg(4'd10, 16'h0000);
        run_frame(lines, fh, fv, rh, rv);
        chk("unlace_lines", lines, 25);
        chk("unlace_long", long_frame, 1);

        // htotal write lands in the shadow until the frame wraps
        n = 0;
        while (vpos !== 11'd10 && n < 20000) begin step(); n++; end
        chk("reach_vpos10", vpos, 10);
        wr_reg(4'd0, 16'd99);
        chk("htot_hold", htotal_out, 227);
        wait_eol(n);
        wait_eol(n);
        chk("line_len_pending", n, 228);
        run_frame(lines, fh, fv, rh, rv);
        chk("htot_at_eof", htotal_out, 99);
        chk("htot_before_eof", prev_htot, 227);
        wait_eol(n);
        chk("line_len_new", n, 100);

        // equal start/stop windows never blank
        wr_reg(4'd3, 16'd40); m_hbstrt = 40;
        wr_reg(4'd4, 16'd40); m_hbstop = 40;
        wr_reg(4'd8, 16'd0);  m_vbstrt = 0;
        wr_reg(4'd9, 16'd0);  m_vbstop = 0;
        run_frame(lines, fh, fv, rh, rv);
        clr_err();
        run_frame(lines, fh, fv, rh, rv);
        chk("noblank_cnt", bl_cnt, 0);
        chk("noblank_model", bl_err, 0);
        chk("noblank_lines", lines, 25);

        // inverted hsync polarity, one clk behind hpos
        wr_reg(4'd10, 16'h0002); m_hpol = 1'b1;
        clr_err();
        wait_eol(n);
        n = 0;
        while (hpos !== 9'd18 && n < 1000) begin step(); n++; end
        chk("pol_at18_still_low", _hsync, 0);
        step();
        chk("pol_after18_high", _hsync, 1);
        n = 0;
        while (hpos !== 9'd35 && n < 1000) begin step(); n++; end
        chk("pol_at35_still_high", _hsync, 1);
        step();
        chk("pol_after35_low", _hsync, 0);
        wait_eol(n);
        chk("pol_line_model", hs_err, 0);

        // asynchronous reset mid-frame
        n = 0;
        while (!(hpos === 9'd60 && vpos === 11'd12) && n < 5000) begin step(); n++; end
        chk("reach_60_12", {hpos, vpos}, {9'd60, 11'd12});
        #2 reset = 1'b1;
        #1;
        chk("arst_hpos", hpos, 0);
        chk("arst_vpos", vpos, 0);
        chk("arst_long", long_frame, 1);
        chk("arst_blank", blank, 1);
        chk("arst_hsync", _hsync, 1);
        chk("arst_vsync", _vsync, 1);
        chk("arst_eol", eol, 0);
        chk("arst_eof", eof, 0);
        chk("arst_htotal", htotal_out, 227);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("restart_hpos", hpos, 1);
        chk("restart_vpos", vpos, 0);
        wait_eol(n);
        chk("restart_line", n, 227);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
